el2_ifu_cdbg_ctl: RTL

EL2_IFU_CDBG_CTL -- requirements
Module: el2_ifu_cdbg_ctl

---
 rtl/el2_pkg.sv | 16 +
 rtl/el2_cdbg_parity.sv | 8 +
 rtl/el2_ifu_cdbg_ctl.sv | 96 +++++++++
 3 files changed

// File: rtl/el2_pkg.sv
// el2_pkg: shared cache-debug request packet and debug-controller state encoding
package el2_pkg;
  typedef struct packed {
    logic [70:0] icache_wrdata;
    logic [16:0] icache_dicawics;
    logic        icache_rd_valid;
    logic        icache_wr_valid;
  } el2_cache_debug_pkt_t;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    ACCESS = 3'd2,
    RDWAIT = 3'd3,
    DONE   = 3'd4
  } el2_cdbg_state_t;
endpackage

// File: rtl/el2_cdbg_parity.sv
// el2_cdbg_parity: even-parity check of a data-array read (two 32-bit halves, parity bits 64/65)
// Ports: rddata - low 66 bits of the array word; err - either half mismatches its parity bit.
module el2_cdbg_parity (
  input  logic [65:0] rddata,
  output logic        err
);
  assign err = ((^rddata[31:0]) != rddata[64]) | ((^rddata[63:32]) != rddata[65]);
endmodule

// File: rtl/el2_ifu_cdbg_ctl.sv
// el2_ifu_cdbg_ctl: arbitrates debug I-cache array reads/writes against instruction fetch
// Ports: clk/rst_l (async active-low); dbg_pkt in, dbg_busy/dbg_rddata/dbg_rd_done/dbg_wr_done/dbg_err out;
//        ifu_fetch_req in, ifu_fetch_gnt out; arr_* drive the cache arrays, arr_rddata returns read data.
// Optional: EL2_ICACHE_DBG_PARITY_EN adds a parity check on data-array reads (dbg_err), else dbg_err = 0.
module el2_ifu_cdbg_ctl
  import el2_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  el2_cache_debug_pkt_t dbg_pkt,
  output logic                 dbg_busy,
  input  logic                 ifu_fetch_req,
  output logic                 ifu_fetch_gnt,
  output logic                 arr_rd_en,
  output logic                 arr_wr_en,
  output logic                 arr_sel,
  output logic [1:0]           arr_way,
  output logic [13:0]          arr_index,
  output logic [70:0]          arr_wrdata,
  input  logic [70:0]          arr_rddata,
  output logic [70:0]          dbg_rddata,
  output logic                 dbg_rd_done,
  output logic                 dbg_wr_done,
  output logic                 dbg_err
);
  el2_cdbg_state_t state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [1:0]  lat_cnt;
  logic        req_wr;
  logic [16:0] req_addr;
  logic [70:0] req_data;
  logic        req_in, starve_hit, lat_hit, rd_cap;
  assign req_in     = dbg_pkt.icache_rd_valid | dbg_pkt.icache_wr_valid;
  // Pre-empt on the granted cycle that brings the counter up to STARVE_MAX,
  // so fetch gets exactly STARVE_MAX grants while debug waits.
  assign starve_hit = (starve_cnt + 4'd1) == 4'(STARVE_MAX);
  assign lat_hit    = lat_cnt == 2'(RD_LAT - 1);
  assign rd_cap     = (state == RDWAIT) & lat_hit;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_in ? ARB : IDLE;
      ARB:     state_nxt = (!ifu_fetch_req || starve_hit) ? ACCESS : ARB;
      ACCESS:  state_nxt = req_wr ? DONE : RDWAIT;
      RDWAIT:  state_nxt = lat_hit ? DONE : RDWAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      dbg_rddata <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= (state == DONE) ? 4'd0 : ((state == ARB) && ifu_fetch_req) ? starve_cnt + 4'd1 : starve_cnt;
      lat_cnt    <= (state == RDWAIT) ? lat_cnt + 2'd1 : 2'd0;
      if ((state == IDLE) && req_in) begin
        req_wr   <= dbg_pkt.icache_wr_valid;
        req_addr <= dbg_pkt.icache_dicawics;
        req_data <= dbg_pkt.icache_wrdata;
      end
      if (rd_cap) dbg_rddata <= arr_rddata;
    end
  end
`ifdef EL2_ICACHE_DBG_PARITY_EN
  logic par_err;
  el2_cdbg_parity u_parity (
    .rddata(arr_rddata[65:0]),
    .err   (par_err)
  );
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dbg_err <= 1'b0;
    else if (rd_cap) dbg_err <= par_err & ~req_addr[16];
  end
`else
  assign dbg_err = 1'b0;
`endif
  assign dbg_busy      = state != IDLE;
  assign ifu_fetch_gnt = ifu_fetch_req & (state != ACCESS) & (state != RDWAIT);
  assign arr_rd_en     = (state == ACCESS) & ~req_wr;
  assign arr_wr_en     = (state == ACCESS) & req_wr;
  assign arr_sel       = req_addr[16];
  assign arr_way       = req_addr[15:14];
  assign arr_index     = req_addr[13:0];
  assign arr_wrdata    = req_data;
  assign dbg_rd_done   = (state == DONE) & ~req_wr;
  assign dbg_wr_done   = (state == DONE) & req_wr;
endmodule
